prio_enc_scan: RTL and testbench



---
 rtl/prio_enc_scan.sv | 139 +++++++++++++
 tb/tb_prio_enc_scan.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/prio_enc_scan.sv
// rtl/prio_enc_scan.sv - sequential priority encoder: reports every set request bit, highest first
// Optional feature macro: PRIO_ENC_SCAN_COUNT_EN (adds the remain output)
module prio_enc_scan #(
    parameter int WIDTH  = 8,
    parameter int CODE_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              load,
    input  logic [WIDTH-1:0]  data,
    output logic              idle,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] code,
    output logic              last,
    output logic              zero
`ifdef PRIO_ENC_SCAN_COUNT_EN
    ,
    output logic [CODE_W:0]   remain
`endif
);

    generate
        if (WIDTH < 2 || WIDTH > 256 || CODE_W != $clog2(WIDTH)) begin : g_bad_param
            $error("prio_enc_scan: WIDTH must be 2..256 and CODE_W must equal clog2(WIDTH)");
        end
    endgenerate

    typedef enum logic {
        S_IDLE,
        S_SCAN
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   pending;
    logic [CODE_W-1:0]  msb_idx;
    logic [WIDTH-1:0]   msb_mask;
    logic               single;
    logic               xfer;

    // Locate the highest pending bit and detect a single remaining bit
    always_comb begin
        msb_idx  = '0;
        msb_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (pending[i]) begin
                msb_idx     = CODE_W'(i);
                msb_mask    = '0;
                msb_mask[i] = 1'b1;
            end
        end
        single = (pending != '0) && ((pending & (pending - WIDTH'(1))) == '0);
    end

    // Outputs are forced to 0 outside a scan so nothing undefined leaks out
    assign code = out_valid ? msb_idx : '0;
    assign last = out_valid & single;
    assign xfer = out_valid & out_ready;

`ifdef PRIO_ENC_SCAN_COUNT_EN
    logic [CODE_W:0] ones;

    // Population count of the incoming vector, used to seed remain
    always_comb begin
        ones = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + (CODE_W + 1)'(data[i]);
        end
    end

    // Count of indices still to be reported in the current scan
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remain <= '0;
        end else if (!en) begin
            remain <= '0;
        end else if (state == S_IDLE) begin
            if (load && data != '0) begin
                remain <= ones;
            end
        end else if (xfer) begin
            remain <= remain - 1'b1;
        end
    end
`endif

    // Scan controller: capture, hand out one index per handshake, return to idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pending   <= '0;
            idle      <= 1'b1;
            out_valid <= 1'b0;
            zero      <= 1'b0;
        end else if (!en) begin
            state     <= S_IDLE;
            pending   <= '0;
            idle      <= 1'b1;
            out_valid <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    zero <= 1'b0;
                    if (load) begin
                        if (data != '0) begin
                            pending   <= data;
                            state     <= S_SCAN;
                            idle      <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            zero <= 1'b1;
                        end
                    end
                end
                S_SCAN: begin
                    zero <= 1'b0;
                    if (xfer) begin
                        pending <= pending & ~msb_mask;
                        if (single) begin
                            state     <= S_IDLE;
                            idle      <= 1'b1;
                            out_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    pending   <= '0;
                    idle      <= 1'b1;
                    out_valid <= 1'b0;
                    zero      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prio_enc_scan.sv
// tb/tb_prio_enc_scan.sv - self-checking bench for prio_enc_scan
module tb_prio_enc_scan;

    localparam int WIDTH  = 8;
    localparam int CODE_W = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic              load;
    logic [WIDTH-1:0]  data;
    logic              idle;
    logic              out_valid;
    logic              out_ready;
    logic [CODE_W-1:0] code;
    logic              last;
    logic              zero;
`ifdef PRIO_ENC_SCAN_COUNT_EN
    logic [CODE_W:0]   remain;
`endif

    int checks = 0;
    int errors = 0;

    prio_enc_scan #(.WIDTH(WIDTH), .CODE_W(CODE_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .load      (load),
        .data      (data),
        .idle      (idle),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .code      (code),
        .last      (last),
        .zero      (zero)
`ifdef PRIO_ENC_SCAN_COUNT_EN
        ,
        .remain    (remain)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] vec;
        int         exp_first;
        int         exp_n;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [7:0] d);
        en   = 1'b1;
        load = 1'b1;
        data = d;
        @(negedge clk);
        load = 1'b0;
        data = '0;
    endtask

    // Expected indices come straight from the vector: every set bit, highest first
    task automatic drain(input logic [7:0] d, input int rdy_pct, output int n_xfer, output int first);
        int q[$];
        int cycles;
        for (int i = WIDTH - 1; i >= 0; i--) if (d[i]) q.push_back(i);
        n_xfer = 0;
        first  = -1;
        cycles = 0;
        while (q.size() > 0 && cycles < 200) begin
            chk("valid", 32'(out_valid), 1);
            chk("idle_scan", 32'(idle), 0);
            chk("code", 32'(code), 32'(q[0]));
            chk("last", 32'(last), 32'(q.size() == 1));
`ifdef PRIO_ENC_SCAN_COUNT_EN
            chk("remain", 32'(remain), 32'(q.size()));
`endif
            if (first < 0) first = int'(code);
            out_ready = ($urandom_range(0, 99) < rdy_pct);
            if (out_ready) begin
                void'(q.pop_front());
                n_xfer++;
            end
            @(negedge clk);
            cycles++;
        end
        if (q.size() > 0) chk("drain_timeout", 32'(q.size()), 0);
        out_ready = 1'b0;
        chk("valid_end", 32'(out_valid), 0);
        chk("idle_end", 32'(idle), 1);
        chk("code_end", 32'(code), 0);
    endtask

    task automatic expect_zero();
        chk("zero_pulse", 32'(zero), 1);
        chk("zero_idle", 32'(idle), 1);
        chk("zero_valid", 32'(out_valid), 0);
        @(negedge clk);
        chk("zero_drop", 32'(zero), 0);
    endtask

    initial begin
        vec_t tbl[6];
        int   n, f;
        logic [7:0] d;

        tbl[0] = '{8'b1001_0110, 7, 4};
        tbl[1] = '{8'b0100_0001, 6, 2};
        tbl[2] = '{8'h01, 0, 1};
        tbl[3] = '{8'h80, 7, 1};
        tbl[4] = '{8'hFF, 7, 8};
        tbl[5] = '{8'h00, -1, 0};

        rst_n = 1'b0; en = 1'b0; load = 1'b0; data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_idle", 32'(idle), 1);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_code", 32'(code), 0);
        chk("rst_last", 32'(last), 0);
        chk("rst_zero", 32'(zero), 0);
        rst_n = 1'b1;
        en    = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 6; t++) begin
            do_load(tbl[t].vec);
            if (tbl[t].vec == 8'h00) begin
                expect_zero();
            end else begin
                drain(tbl[t].vec, 100, n, f);
                chk("tbl_first", 32'(f), 32'(tbl[t].exp_first));
                chk("tbl_count", 32'(n), 32'(tbl[t].exp_n));
            end
        end

        // Backpressure holds code/last stable
        do_load(8'b0100_0001);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("bp_code", 32'(code), 6);
            chk("bp_last", 32'(last), 0);
            @(negedge clk);
        end
        drain(8'b0100_0001, 100, n, f);

        // Load during a scan is ignored
        do_load(8'h03);
        chk("ign_code1", 32'(code), 1);
        load = 1'b1; data = 8'h80; out_ready = 1'b1;
        @(negedge clk);
        load = 1'b0; data = '0;
        chk("ign_code0", 32'(code), 0);
        chk("ign_last", 32'(last), 1);
        @(negedge clk);
        out_ready = 1'b0;
        chk("ign_done", 32'(out_valid), 0);
        @(negedge clk);
        chk("ign_stay_idle", 32'(idle), 1);
        chk("ign_no_valid", 32'(out_valid), 0);

        // Abort with en low after two transfers
        do_load(8'hFF);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_pre", 32'(code), 5);
        en = 1'b0;
        @(negedge clk);
        chk("abort_valid", 32'(out_valid), 0);
        chk("abort_idle", 32'(idle), 1);
        chk("abort_code", 32'(code), 0);
        out_ready = 1'b0;
        en = 1'b1;
        @(negedge clk);
        chk("abort_no_resume", 32'(out_valid), 0);
        do_load(8'h01);
        chk("reen_code", 32'(code), 0);
        chk("reen_last", 32'(last), 1);
        drain(8'h01, 100, n, f);

        // Asynchronous reset mid-scan
        do_load(8'b1010_0000);
        chk("ar_pre", 32'(code), 7);
        rst_n = 1'b0;
        #1;
        chk("ar_idle", 32'(idle), 1);
        chk("ar_valid", 32'(out_valid), 0);
        chk("ar_code", 32'(code), 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("ar_silent", 32'(out_valid), 0);
        end
        out_ready = 1'b0;

        // Randomized vectors and handshake timing against the queue model
        for (int r = 0; r < 40; r++) begin
            d = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            do_load(d);
            if (d == 8'h00) expect_zero();
            else drain(d, $urandom_range(30, 100), n, f);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
